// File: rtl/hack_data_mem.sv
// Hack data-memory responder: decodes RAM / screen / keyboard and arbitrates the screen RAM between CPU and video scanout.
// Latency: CPU and video reads return data 2 cycles after acceptance; writes commit on the accepting edge.
// Backpressure: mem_busy stalls the CPU only while video owns the screen port; video gets at most MAX_VID_RUN grants while the CPU waits.
//
// Ports: clk/reset (synchronous, active-high); CPU bus mem_address/mem_write/mem_wdata -> mem_rdata/mem_busy;
//        video port vid_req/vid_addr -> vid_grant/vid_rdata/vid_valid; kbd_code asynchronous keyboard input.
// Optional: define HACK_DATA_MEM_BUSERR_EN to add bus_err, a sticky flag raised by writes to unmapped addresses.
module hack_data_mem #(
    parameter int          RAM_WORDS    = 16384,
    parameter logic [15:0] SCREEN_BASE  = 16'h4000,
    parameter int          SCREEN_WORDS = 8192,
    parameter logic [15:0] KBD_ADDR     = 16'h6000,
    parameter int          MAX_VID_RUN  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_address,
    input  logic        mem_write,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_busy,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic        vid_grant,
    output logic [15:0] vid_rdata,
    output logic        vid_valid,
    input  logic [15:0] kbd_code
`ifdef HACK_DATA_MEM_BUSERR_EN
    ,
    output logic        bus_err
`endif
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);
    localparam int CNT_W  = $clog2(MAX_VID_RUN + 1);
    localparam logic [16:0]      RAM_END = 17'(RAM_WORDS);
    localparam logic [16:0]      SCR_END = 17'(SCREEN_BASE) + 17'(SCREEN_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_VID_RUN);

    typedef enum logic [1:0] {REG_RAM, REG_SCR, REG_KBD, REG_UNM} region_t;

    logic [15:0] ram_mem [RAM_WORDS];
    logic [15:0] scr_mem [SCREEN_WORDS];

    region_t          region;
    logic             cpu_scr, vid_gnt, accept, wr_ram, wr_scr;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_off, scr_port_addr;
    logic [15:0]      ram_rd_q, scr_rd_q;

    logic [CNT_W-1:0] run_cnt_d, run_cnt_q;
    logic             cpu_vld1_d, cpu_vld1_q;
    region_t          cpu_reg1_d, cpu_reg1_q;
    logic [15:0]      kbd1_d, kbd1_q;
    logic             vid_vld1_d, vid_vld1_q;
    logic [15:0]      mem_rdata_d, mem_rdata_q;
    logic [15:0]      vid_rdata_d, vid_rdata_q;
    logic             vid_valid_d, vid_valid_q;
    logic [15:0]      kbd_meta_d, kbd_meta_q, kbd_sync_d, kbd_sync_q;
    logic             bus_err_d, bus_err_q;

    // Region decode
    always_comb begin
        region = REG_UNM;
        if ({1'b0, mem_address} < RAM_END)
            region = REG_RAM;
        else if (mem_address >= SCREEN_BASE && {1'b0, mem_address} < SCR_END)
            region = REG_SCR;
        else if (mem_address == KBD_ADDR)
            region = REG_KBD;
    end

    assign ram_idx = mem_address[RAM_AW-1:0];
    assign scr_off = mem_address[SCR_AW-1:0] - SCREEN_BASE[SCR_AW-1:0];

    // Screen port arbitration. The CPU has no read strobe, so any screen
    // address is a request; run_cnt caps how long video can starve it.
    always_comb begin
        cpu_scr       = (region == REG_SCR);
        vid_gnt       = !reset && vid_req && (!cpu_scr || run_cnt_q < CNT_MAX);
        mem_busy      = reset || (cpu_scr && vid_gnt);
        accept        = !mem_busy;
        wr_ram        = mem_write && accept && (region == REG_RAM);
        wr_scr        = mem_write && accept && (region == REG_SCR);
        // One physical port: video address when granted, else the CPU's.
        scr_port_addr = vid_gnt ? vid_addr[SCR_AW-1:0] : scr_off;

        run_cnt_d = '0;
        if (!reset && cpu_scr && vid_gnt)
            run_cnt_d = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_W'(1);
    end

    // Read pipeline stage 1 / stage 2 and keyboard synchroniser
    always_comb begin
        cpu_vld1_d = accept;
        cpu_reg1_d = region;
        kbd1_d     = kbd_sync_q;
        vid_vld1_d = vid_gnt;

        mem_rdata_d = mem_rdata_q;
        if (reset)
            mem_rdata_d = '0;
        else if (cpu_vld1_q) begin
            case (cpu_reg1_q)
                REG_RAM: mem_rdata_d = ram_rd_q;
                REG_SCR: mem_rdata_d = scr_rd_q;
                REG_KBD: mem_rdata_d = kbd1_q;
                default: mem_rdata_d = '0;
            endcase
        end

        // scr_rd_q carries either a CPU or a video read, never both,
        // because a CPU screen access is only accepted without a video grant.
        vid_valid_d = !reset && vid_vld1_q;
        vid_rdata_d = reset ? 16'h0 : (vid_vld1_q ? scr_rd_q : vid_rdata_q);

        kbd_meta_d = reset ? 16'h0 : kbd_code;
        kbd_sync_d = reset ? 16'h0 : kbd_meta_q;
        bus_err_d  = reset ? 1'b0 : (bus_err_q || (region == REG_UNM && mem_write));
    end

    // Arrays: read registered every cycle, read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (wr_ram)
            ram_mem[ram_idx] <= mem_wdata;
        ram_rd_q <= ram_mem[ram_idx];
        if (wr_scr)
            scr_mem[scr_off] <= mem_wdata;
        scr_rd_q <= scr_mem[scr_port_addr];
    end

    // Reset is folded into the _d terms, so every flop simply loads its _d.
    always_ff @(posedge clk) begin
        run_cnt_q   <= run_cnt_d;
        cpu_vld1_q  <= cpu_vld1_d;
        cpu_reg1_q  <= cpu_reg1_d;
        kbd1_q      <= kbd1_d;
        vid_vld1_q  <= vid_vld1_d;
        mem_rdata_q <= mem_rdata_d;
        vid_rdata_q <= vid_rdata_d;
        vid_valid_q <= vid_valid_d;
        kbd_meta_q  <= kbd_meta_d;
        kbd_sync_q  <= kbd_sync_d;
        bus_err_q   <= bus_err_d;
    end

    assign mem_rdata = mem_rdata_q;
    assign vid_grant = vid_gnt;
    assign vid_rdata = vid_rdata_q;
    assign vid_valid = vid_valid_q;

`ifdef HACK_DATA_MEM_BUSERR_EN
    assign bus_err = bus_err_q;
`else
    // Unmapped writes are dropped silently; the flag has no consumer.
    logic unused_bus_err;
    assign unused_bus_err = bus_err_q;
`endif

endmodule

// File: doc/hack_data_mem.md
Name: hack_data_mem

Overview:
- Responder end of the CPU data-memory bus: the CPU drives address, write strobe and write data; this block returns read data and a busy stall.
- Decodes the Hack memory map: RAM, screen framebuffer and keyboard register.
- Arbitrates the single-port screen RAM between CPU accesses and a video scanout read port.
- Sits between the CPU and the display controller / keyboard front end.

Parameters:
- RAM_WORDS, 16384, general RAM depth; words 0x0000 to RAM_WORDS-1.
- SCREEN_BASE, 16'h4000, first screen word address.
- SCREEN_WORDS, 8192, screen RAM depth.
- KBD_ADDR, 16'h6000, keyboard register address.
- MAX_VID_RUN, 4, max consecutive video grants while the CPU is waiting on the screen.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- mem_address  in  16  CPU word address
- mem_write  in  1  CPU write strobe
- mem_wdata  in  16  CPU write data
- mem_rdata  out  16  read data
- mem_busy  out  1  stall; CPU must hold its request while high
- vid_req  in  1  video read request; held until granted
- vid_addr  in  13  screen word offset
- vid_grant  out  1  video request accepted this cycle
- vid_rdata  out  16  video read data
- vid_valid  out  1  vid_rdata valid strobe
- kbd_code  in  16  asynchronous keyboard scancode

Behaviour:
- Region decode, combinational on mem_address:
  - RAM if address < RAM_WORDS.
  - SCREEN if SCREEN_BASE <= address < SCREEN_BASE+SCREEN_WORDS.
  - KBD if address == KBD_ADDR.
  - Otherwise UNMAPPED.
- mem_busy, combinational:
  - 1 while reset.
  - 1 when the region is SCREEN and the screen port is granted to video this cycle.
  - 0 otherwise. RAM, KBD and UNMAPPED never stall.
- Screen port arbitration, decided each cycle:
  - cpu_scr = region is SCREEN (CPU sends no read strobe, so any SCREEN address counts as a request).
  - If vid_req and (!cpu_scr or run_cnt < MAX_VID_RUN): grant video.
  - Else if cpu_scr: grant CPU.
  - Else idle.
- run_cnt:
  - Increments on each video grant while cpu_scr.
  - Clears on a CPU grant, or on any cycle with !cpu_scr.
  - Saturates at MAX_VID_RUN.
  - Guarantees the CPU a grant within MAX_VID_RUN+1 cycles.
- Write:
  - Commits on the rising edge of a cycle with mem_write=1 and mem_busy=0.
  - RAM or SCREEN word at mem_address takes mem_wdata.
  - Writes to KBD or UNMAPPED are ignored.
  - A write stalled by busy must not commit.
- Read latency: exactly 2 cycles.
  - If mem_busy=0 at cycle N, mem_rdata at N+2 equals the word at the cycle-N address.
  - RAM/SCREEN: registered array read in N+1, output register in N+2.
  - KBD: kbd_sync value; UNMAPPED: 0.
  - mem_rdata holds between updates.
  - During busy cycles, mem_rdata keeps its previous value.
- Read during write to the same address: returns old data (read-before-write).
- Video path:
  - vid_grant=1 in the grant cycle.
  - vid_valid=1 for one cycle exactly 2 cycles later, with vid_rdata = screen[vid_addr as sampled in the grant cycle].
  - Back-to-back grants give back-to-back vid_valid.
- kbd_code passes through a 2-flop synchroniser into kbd_sync; a change appears after 2 edges.
- Reset values:
  - mem_rdata=0, vid_rdata=0, vid_valid=0, vid_grant=0, run_cnt=0, kbd_sync=0.
  - The read pipeline is flushed: no vid_valid for grants issued before or during reset.
  - RAM contents are not cleared.
- A reset arriving mid-read cancels the outstanding mem_rdata and vid_valid updates.

Optional Feature:
- Macro HACK_DATA_MEM_BUSERR_EN adds output bus_err (1 bit).
- With the macro: bus_err is a sticky flag, set on the edge after any cycle where the region is UNMAPPED and mem_write=1. Cleared only by reset.
- Without the macro: the port is absent. Unmapped writes are silently dropped, unmapped reads return 0.

Test Plan:
- Write 0x1234 to 0x0010 (busy low), then present 0x0010 -> mem_rdata=0x1234 two cycles after presentation; unchanged before.
- vid_req held with vid_addr=0x0005 after the CPU writes 0xBEEF to 0x4005, no CPU screen access -> vid_grant at cycle N, vid_valid with vid_rdata=0xBEEF at N+2.
- CPU holds 0x4000 with mem_write=1, data 0x00FF, while vid_req stays high (MAX_VID_RUN=4) -> mem_busy=1 for exactly 4 cycles, then 0. Write commits only on that cycle; screen[0] reads 0x00FF.
- kbd_code changes 0x0000 to 0x0041; CPU reads 0x6000 -> mem_rdata=0x0041 once kbd_sync has updated (2 edges) plus 2-cycle read latency. A write of 0x7777 to 0x6000 has no effect.
- Read 0x6001 -> mem_rdata=0x0000. Write to 0x7000 -> memory unchanged; with HACK_DATA_MEM_BUSERR_EN, bus_err rises next edge and stays high until reset.
- Assert reset 1 cycle after a video grant -> no vid_valid pulse; all outputs 0; mem_busy=1 during reset and 0 on the first cycle after for a RAM address.
